// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Rotate the round-robin pointer to the slot after the last grant.
    function automatic int next_ptr(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                grant = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master_interface start/done port among NUM_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no transaction outstanding; grant on any req_valid
// ISSUE     | req_ready/m_start pulse visible; payload latched on m_*
// WAIT_DONE | waiting for m_done (or watchdog expiry)
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic                      m_write_en,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic             do_grant;
    logic             do_done;
    logic             do_timeout;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Counter holds the number of completed WAIT_DONE cycles, so the last one is TIMEOUT_CYCLES-1.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    do_grant = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (m_done) begin
                    do_done = 1'b1;
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    do_timeout = 1'b1;
                    state_d    = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_write_en <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= '0;
            m_start   <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (do_grant) begin
                grant_q          <= pick;
                m_addr           <= req_addr[pick*ADDR_W +: ADDR_W];
                m_wdata          <= req_wdata[pick*DATA_W +: DATA_W];
                m_write_en       <= req_write[pick];
                req_ready[pick]  <= 1'b1;
                m_start          <= 1'b1;
            end
            if (do_done || do_timeout) begin
                rsp_valid[grant_q] <= 1'b1;
                ptr_q              <= IDX_W'(next_ptr(int'(grant_q), NUM_REQ));
            end
            if (do_done) rsp_rdata <= m_rdata;
            if (do_timeout) begin
                rsp_rdata <= DATA_W'(ARB_TIMEOUT_DATA);
                rsp_err   <= 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            tmo_q <= '0;
        else if (state_q == WAIT_DONE && state_d == WAIT_DONE)
            tmo_q <= tmo_q + 1'b1;
        else
            tmo_q <= '0;
    end
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (two requesters); watchdog scenario runs when ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_write = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            m_start;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_write_en;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_done  = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_start    (m_start),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_write_en (m_write_en),
        .m_rdata    (m_rdata),
        .m_done     (m_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until m_start is seen, at most 20 cycles; n = cycles taken.
    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_start && n < 20);
    endtask

    task automatic pulse_done(input logic [DW-1:0] rdata);
        m_rdata = rdata;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if (req_ready !== 2'b00 || m_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: req_ready=%b m_start=%b, want 00/0", req_ready, m_start);
        end
        vectors++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: rsp_valid=%b err=%b rdata=%h, want 00/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        vectors++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_payload: addr=%h wdata=%h we=%b, want 0", m_addr, m_wdata, m_write_en);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        req_addr[0 +: AW]  = 32'h2;
        req_wdata[0 +: DW] = 32'h15;
        req_write[0]       = 1'b1;
        req_valid          = 2'b01;
        tick();
        vectors++;
        if (req_ready !== 2'b01 || m_start !== 1'b1) begin
            miscompares++;
            $display("FAIL write_grant: req_ready=%b m_start=%b, want 01/1", req_ready, m_start);
        end
        vectors++;
        if (m_addr !== 32'h2 || m_wdata !== 32'h15 || m_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL write_payload: addr=%h wdata=%h we=%b, want 2/15/1", m_addr, m_wdata, m_write_en);
        end
        req_valid = 2'b00;
        tick();
        vectors++;
        if (req_ready !== 2'b00 || m_start !== 1'b0) begin
            miscompares++;
            $display("FAIL write_pulse_width: req_ready=%b m_start=%b, want 00/0", req_ready, m_start);
        end
        tick(); tick();
        vectors++;
        if (rsp_valid !== 2'b00 || m_start !== 1'b0) begin
            miscompares++;
            $display("FAIL write_wait: rsp_valid=%b m_start=%b, want 00/0", rsp_valid, m_start);
        end
        pulse_done(32'h77);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h77) begin
            miscompares++;
            $display("FAIL write_rsp: rsp_valid=%b err=%b rdata=%h, want 01/0/77", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL write_rsp_width: rsp_valid=%b, want 00", rsp_valid);
        end
    endtask

    // Pointer is 1 here, so requester 1 is next in rotation anyway.
    task automatic test_read_return;
        req_addr[AW +: AW] = 32'h3;
        req_write[1]       = 1'b0;
        req_valid          = 2'b10;
        tick();
        vectors++;
        if (req_ready !== 2'b10 || m_addr !== 32'h3 || m_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL read_grant: req_ready=%b addr=%h we=%b, want 10/3/0", req_ready, m_addr, m_write_en);
        end
        req_valid = 2'b00;
        tick();
        pulse_done(32'h0000_001A);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h1A || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_rsp: rsp_valid=%b rdata=%h err=%b, want 10/1a/0", rsp_valid, rsp_rdata, rsp_err);
        end
        tick();
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_rdy;
        logic [AW-1:0] exp_addr;
        int n;
        req_addr[0 +: AW]  = 32'h10;
        req_addr[AW +: AW] = 32'h20;
        req_write          = 2'b00;
        req_valid          = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_rdy  = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 32'h10 : 32'h20;
            wait_start(n);
            vectors++;
            if (req_ready !== exp_rdy || m_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL contention_grant%0d: req_ready=%b addr=%h, want %b/%h", t, req_ready, m_addr, exp_rdy, exp_addr);
            end
            vectors++;
            if (n !== 1) begin
                miscompares++;
                $display("FAIL contention_latency%0d: %0d cycles to m_start, want 1", t, n);
            end
            tick();
            pulse_done(32'h100 + 32'(t));
            vectors++;
            if (rsp_valid !== exp_rdy || rsp_rdata !== 32'h100 + 32'(t)) begin
                miscompares++;
                $display("FAIL contention_rsp%0d: rsp_valid=%b rdata=%h, want %b/%h", t, rsp_valid, rsp_rdata, exp_rdy, 32'h100 + 32'(t));
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_stray_done;
        pulse_done(32'h55);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_idle_rsp: rsp_valid=%b, want 00", rsp_valid);
        end
        tick();
        vectors++;
        if (m_start !== 1'b0 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_idle_state: m_start=%b req_ready=%b, want 0/00", m_start, req_ready);
        end
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        pulse_done(32'h66);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_issue_rsp: rsp_valid=%b, want 00", rsp_valid);
        end
        pulse_done(32'h67);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h67) begin
            miscompares++;
            $display("FAIL stray_followup_rsp: rsp_valid=%b rdata=%h, want 01/67", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    // Pointer is 1 on entry; a lost reset would leave it there.
    task automatic test_reset_mid;
        int n;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick(); tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (m_start !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: m_start=%b req_ready=%b rsp_valid=%b, want 0", m_start, req_ready, rsp_valid);
        end
        tick();
        rst = 1'b0;
        pulse_done(32'h99);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_late_done: rsp_valid=%b, want 00", rsp_valid);
        end
        req_valid = 2'b11;
        wait_start(n);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_ptr: req_ready=%b after %0d cycles, want 01", req_ready, n);
        end
        req_valid = 2'b00;
        tick();
        pulse_done(32'h0);
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    // Grant observed after edge 1; 16 WAIT_DONE cycles end at edge 18, i.e. 17 ticks later.
    task automatic test_timeout;
        int n;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid === 2'b00 && n < 40);
        vectors++;
        if (n !== 17) begin
            miscompares++;
            $display("FAIL timeout_cycles: rsp after %0d ticks, want 17", n);
        end
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL timeout_rsp: rsp_valid=%b err=%b rdata=%h, want 01/1/deadbeef", rsp_valid, rsp_err, rsp_rdata);
        end
        pulse_done(32'h1);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_late_done: rsp_valid=%b, want 00", rsp_valid);
        end
        req_valid = 2'b11;
        wait_start(n);
        vectors++;
        if (req_ready !== 2'b10 || n !== 1) begin
            miscompares++;
            $display("FAIL timeout_next_grant: req_ready=%b after %0d cycles, want 10 after 1", req_ready, n);
        end
        req_valid = 2'b00;
        tick();
        pulse_done(32'h2);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_next_rsp: rsp_valid=%b err=%b, want 10/0", rsp_valid, rsp_err);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout;
        int n;
        logic seen;
        seen = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (n = 0; n < 40; n++) begin
            tick();
            if (rsp_valid !== 2'b00 || rsp_err !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout_wait: response or error seen without m_done");
        end
        pulse_done(32'h3);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h3) begin
            miscompares++;
            $display("FAIL no_timeout_rsp: rsp_valid=%b err=%b rdata=%h, want 01/0/3", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_return();
        test_contention();
        test_stray_done();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
